fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  request address, valid while imem_req=1.
REQ-006 SHALL have port imem_rvalid  input  1  response strobe; exactly one per request, at least 1 cycle after imem_req.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 SHALL have port pcRedirect  input  1  taken branch or jump; overrides sequential fetch.
REQ-009 SHALL have port pcTarget  input  32  redirect address, valid with pcRedirect.
REQ-010 SHALL have port instr  output  32  head-entry instruction; instr[6:0] drives the decoder opcode.
REQ-011 SHALL have port pc  output  32  head-entry address.
REQ-012 SHALL have port pcPlus4  output  32  pc+4, modulo 2^32.
REQ-013 SHALL have port instr_valid  output  1  head entry present.
REQ-014 SHALL have port instr_ready  input  1  consumer accepts head entry when instr_valid=1.
REQ-015 SHALL have port misaligned  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL hold fetchPC register and a 2-entry FIFO of {pc, instr} pairs; instr/pc/pcPlus4 SHALL show FIFO head, instr_valid = FIFO not empty.
REQ-017 SHALL implement FSM states IDLE (no request outstanding), FETCH (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-018 IDLE: when count<2 and pcRedirect=0, SHALL assert imem_req with imem_addr=fetchPC, go to FETCH; otherwise no request.
REQ-019 FETCH with imem_rvalid=1 and pcRedirect=0: SHALL push {fetchPC, imem_rdata}, fetchPC<=fetchPC+4 (0xFFFF_FFFC wraps to 0), go to IDLE; next request no earlier than the following cycle.
REQ-020 Pop SHALL occur when instr_valid=1 and instr_ready=1; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 Requests SHALL be issued only if count plus outstanding stays ≤2; FIFO SHALL never overflow.
REQ-022 pcRedirect=1 in any state SHALL flush FIFO (instr_valid=0 next cycle) and set fetchPC<=pcTarget; redirect wins over simultaneous pop or push.
REQ-023 Redirect in FETCH without rvalid SHALL go to DROP; redirect in FETCH with rvalid same cycle SHALL discard that response and go to IDLE.
REQ-024 DROP: imem_rvalid SHALL be discarded, return to IDLE; further redirect in DROP SHALL only update fetchPC.
REQ-025 Redirect-to-first-request latency SHALL be exactly 1 cycle when no response is pending.

Reset
REQ-026 rst=1 SHALL immediately set state=IDLE, fetchPC=RESET_PC, FIFO empty, instr_valid=0, imem_req=0, instr=0, pc=0, pcPlus4=4, misaligned=0.
REQ-027 A response arriving after reset release for a pre-reset request SHALL be ignored (state IDLE ignores imem_rvalid).
REQ-028 First imem_req SHALL assert in the first cycle after rst deasserts, address RESET_PC.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with pcTarget[1:0]!=0 SHALL set misaligned=1 (sticky until reset), flush FIFO, and suppress all further requests.
REQ-030 Macro undefined: pcTarget[1:0] SHALL be forced to 2'b00 on redirect; misaligned SHALL be tied 0.

Verification
REQ-031 Reset release, 1-cycle memory returning 0x00000013 -> imem_addr 0,4,8 on alternate cycles; pc=0, pcPlus4=4, instr_valid=1 two cycles after release.
REQ-032 instr_ready=0 held -> exactly 2 entries buffered, no third imem_req; ready=1 -> pops pc 0 then 4 on consecutive cycles.
REQ-033 Redirect to 0x100 while request to 0x8 outstanding, response 3 cycles later -> response dropped, next imem_addr=0x100, head pc=0x100.
REQ-034 Redirect, pop and rvalid in same cycle with 1 entry -> FIFO empty next cycle, fetchPC=pcTarget.
REQ-035 fetchPC=0xFFFF_FFFC -> following request address 0x0, pcPlus4 of that entry=0x0.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misaligned=1, imem_req stays 0; without it, next imem_addr=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 2-entry {pc, instr} buffer.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets latch a sticky halt flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pcRedirect,
    input  logic [31:0] pcTarget,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q    [2];
    logic [31:0] instr_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr;
    logic        req_raw;
    logic        push;
    logic        pop;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign target = pcTarget;
    assign mis_d  = mis_q | (pcRedirect & (pcTarget[1:0] != 2'b00));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misaligned = mis_q;
`else
    logic unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^pcTarget[1:0];
    assign target          = {pcTarget[31:2], 2'b00};
    assign misaligned      = 1'b0;
`endif

    // Only IDLE issues, so count < 2 here already bounds count + outstanding to 2.
    assign req_raw   = (state_q == StIdle) && (count_q != 2'd2) && !pcRedirect && !misaligned;
    assign imem_req  = req_raw & ~rst;
    assign imem_addr = fetch_pc_q;

    assign instr_valid = (count_q != 2'd0);
    assign push        = (state_q == StFetch) && imem_rvalid && !pcRedirect;
    assign pop         = instr_valid && instr_ready;
    assign wr_ptr      = rd_ptr_q ^ count_q[0];

    assign instr   = instr_q[rd_ptr_q];
    assign pc      = pc_q[rd_ptr_q];
    assign pcPlus4 = pc + 32'd4;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_raw) state_d = StFetch;
            StFetch: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                end else if (pcRedirect) begin
                    state_d = StDrop;
                end
            end
            StDrop:  if (imem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Redirect flushes and retargets; it takes priority over any push or pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        if (pcRedirect) begin
            fetch_pc_d = target;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + 32'd4;
            case ({push, pop})
                2'b10: count_d = count_q + 2'd1;
                2'b01: begin
                    count_d  = count_q - 2'd1;
                    rd_ptr_d = ~rd_ptr_q;
                end
                2'b11: rd_ptr_d = ~rd_ptr_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q[0]    <= 32'd0;
            pc_q[1]    <= 32'd0;
            instr_q[0] <= 32'd0;
            instr_q[1] <= 32'd0;
        end else if (push) begin
            pc_q[wr_ptr]    <= fetch_pc_q;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked against a
// queue-based reference model and an in-order memory model with 1-3 cycle latency.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pcRedirect;
    logic [31:0] pcTarget;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pcRedirect (pcRedirect),
        .pcTarget   (pcTarget),
        .instr      (instr),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mrsp_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    bit          m_out;
    bit          m_drop;
    bit          m_mis;

    mrsp_t memq[$];
    int    last_due = -1;
    int    cyc = 0;
    int    lat_fix = 1;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_p4;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pcRedirect  = 1'b0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_pcplus4", pcPlus4, 32'd4);
        chk("rst_misaligned", misaligned, 0);
        mq.delete();
        m_fpc  = RESET_PC;
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_mis  = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input bit rd, input logic [31:0] tg, input bit rdy);
        bit          rv;
        bit          exp_req;
        bit          push_ok;
        bit          bad;
        logic [31:0] rdat;
        logic [31:0] tg_eff;
        int          due;
        ent_t        e;
        mrsp_t       r;
        rv   = 1'b0;
        rdat = $urandom();
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rv   = 1'b1;
            rdat = memq[0].data;
            void'(memq.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata  = rdat;
        pcRedirect  = rd;
        pcTarget    = tg;
        instr_ready = rdy;
        #1;
        exp_req = !m_out && (mq.size() < 2) && !rd && !m_mis;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_fpc);
        chk("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("pc", pc, mq[0].pc);
            chk("instr", instr, mq[0].ins);
            chk("pcplus4", pcPlus4, mq[0].pc + 32'd4);
        end
        chk("misaligned", misaligned, m_mis);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = pc;
        obs_p4    = pcPlus4;
        if (imem_req === 1'b1) begin
            due = cyc + ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3)));
            if (due <= last_due) due = last_due + 1;
            r.due  = due;
            r.data = $urandom();
            memq.push_back(r);
            last_due = due;
        end
        @(posedge clk);
        push_ok = 1'b0;
        if (rv && m_out) begin
            push_ok = !m_drop;
            m_out   = 1'b0;
            m_drop  = 1'b0;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        tg_eff = tg;
        bad    = (tg[1:0] != 2'b00);
`else
        tg_eff = {tg[31:2], 2'b00};
        bad    = 1'b0;
`endif
        if (rd) begin
            mq.delete();
            m_fpc = tg_eff;
            if (bad) m_mis = 1'b1;
            if (m_out) m_drop = 1'b1;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (push_ok) begin
                e.pc  = m_fpc;
                e.ins = rdat;
                mq.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
        end
        if (exp_req) begin
            m_out  = 1'b1;
            m_drop = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tg;
        bit          got;
        logic [31:0] got_addr;
        rst         = 1'b0;
        pcRedirect  = 1'b0;
        pcTarget    = 32'd0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        @(negedge clk);
        do_reset();

        // Sequential fetch with 1-cycle memory, consumer stalled.
        lat_fix = 1;
        step(0, 0, 0);
        chk("first_req", obs_req, 1);
        chk("first_addr", obs_addr, RESET_PC);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("c2_valid", obs_valid, 1);
        chk("c2_pc", obs_pc, 32'h0);
        chk("c2_pcplus4", obs_p4, 32'h4);
        chk("c2_addr", obs_addr, 32'h4);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("full_no_req_a", obs_req, 0);
        step(0, 0, 0);
        chk("full_no_req_b", obs_req, 0);
        step(0, 0, 1);
        chk("pop0_pc", obs_pc, 32'h0);
        lat_fix = 3;
        step(0, 0, 1);
        chk("pop1_pc", obs_pc, 32'h4);
        chk("req8_addr", obs_addr, 32'h8);

        // Redirect while the request to 0x8 is outstanding.
        step(1, 32'h100, 0);
        step(0, 0, 0);
        chk("drop_no_req", obs_req, 0);
        step(0, 0, 0);
        lat_fix = 1;
        step(0, 0, 0);
        chk("redir_addr", obs_addr, 32'h100);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("redir_head_pc", obs_pc, 32'h100);

        // Redirect, pop and response all in one cycle with one entry buffered.
        step(1, 32'h200, 1);
        step(0, 0, 0);
        chk("flush_valid", obs_valid, 0);
        chk("flush_req", obs_req, 1);
        chk("flush_addr", obs_addr, 32'h200);

        // Address wrap at the top of the space.
        step(1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0);
        chk("wrap_top_addr", obs_addr, 32'hFFFF_FFFC);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("wrap_addr", obs_addr, 32'h0);
        chk("wrap_pcplus4", obs_p4, 32'h0);

        // Random traffic.
        lat_fix = 0;
        for (int i = 0; i < 1500; i++) begin
            tg = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
            tg[1:0] = 2'b00;
`endif
            step($urandom_range(0, 9) == 0, tg, $urandom_range(0, 3) != 0);
        end

        // Reset with a request in flight; its response lands after release.
        lat_fix = 2;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 0, $urandom_range(0, 1) != 0);
            got = obs_req;
        end
        chk("req_before_rst", got, 1);
        do_reset();
        step(0, 0, 1);
        chk("post_rst_req", obs_req, 1);
        chk("post_rst_addr", obs_addr, RESET_PC);
        step(0, 0, 1);
        chk("stale_ignored", obs_valid, 0);
        lat_fix = 0;
        for (int i = 0; i < 300; i++) begin
            tg = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
            tg[1:0] = 2'b00;
`endif
            step($urandom_range(0, 7) == 0, tg, $urandom_range(0, 1) != 0);
        end

        // Misaligned redirect target.
        lat_fix = 1;
        step(1, 32'h102, 1);
        got      = 1'b0;
        got_addr = 32'd0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            if (!got && obs_req === 1'b1) begin
                got      = 1'b1;
                got_addr = obs_addr;
            end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", misaligned, 1);
        chk("mis_no_req", got, 0);
`else
        chk("mis_flag", misaligned, 0);
        chk("mis_req", got, 1);
        chk("mis_addr", got_addr, 32'h100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
